mux41_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer driving the 4:1 mux select for a shared output channel.
//  - Four sources compete for one sink using valid/ready handshakes.
//  - Grants are packet-based: a grant is held until the source's last beat or until MAX_BURST beats.
//  - The block owns the mux select (sel) and steers out_ready back to the granted source only.

---
 rtl/mux41_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux41_rr_arbiter.sv
// mux41_rr_arbiter
//   Round-robin arbiter that owns the 4:1 mux select for a shared output
//   channel. Four valid/ready sources compete for one sink. A grant lasts
//   for one packet: it is released on the source's last beat or after
//   MAX_BURST beats. At least one IDLE cycle separates consecutive grants.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-source valid (bit i = source i)
//   data_in    source i data at [i*WIDTH +: WIDTH]
//   last_in    per-source end-of-packet flag
//   ready_in   per-source ready, only the granted bit can be 1
//   out_valid  valid toward the sink
//   out_data   muxed data toward the sink
//   out_last   muxed last flag
//   out_ready  sink ready
//   sel        registered mux select (index of the granted source)
//   grant      one-hot grant, all 0 when idle
//   busy       1 while a grant is held
//
// State  | Meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate round-robin starting at ptr
// GRANT  | source sel owns the channel until last beat or MAX_BURST beats
module mux41_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data_in,
    input  logic [3:0]         last_in,
    output logic [3:0]         ready_in,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [1:0]         sel,
    output logic [3:0]         grant,
    output logic               busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [CW-1:0]   beat_cnt;

    logic [1:0]      pick;
    logic [1:0]      cand;
    logic            pick_found;
    logic            xfer;
    logic            rel;

    // First requesting source scanning ptr, ptr+1, ... with 2-bit wrap.
    always_comb begin
        pick_found = 1'b0;
        pick       = ptr;
        cand       = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign busy = (state == GRANT);
    assign xfer = busy && req[sel] && out_ready;
    assign rel  = xfer && (last_in[sel] || (beat_cnt == CW'(MAX_BURST - 1)));

    always_comb begin
        ready_in  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (busy) begin
            ready_in[sel] = out_ready;
            out_valid     = req[sel];
            out_data      = data_in[int'(sel)*WIDTH +: WIDTH];
            out_last      = last_in[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel      <= pick;
                        grant    <= 4'b0001 << pick;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // sel is left alone on release so the mux stays put.
                    if (rel) begin
                        state    <= IDLE;
                        grant    <= '0;
                        ptr      <= sel + 2'd1;
                        beat_cnt <= '0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb_mux41_rr_arbiter
//   Bench for mux41_rr_arbiter: directed scenarios with literal expectations
//   followed by randomized traffic, all outputs compared every cycle against
//   a packet-level reference model.
module tb_mux41_rr_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [3:0]     last_in;
    logic [3:0]     ready_in;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     sel;
    logic [3:0]     grant;
    logic           busy;

    mux41_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = nobody), beats taken in this packet,
    // round-robin start point and the last select value driven.
    int own   = -1;
    int mptr  = 0;
    int mbeat = 0;
    int msel  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own   = -1;
            mptr  = 0;
            mbeat = 0;
            msel  = 0;
        end else if (own < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (own < 0 && req[(mptr + k) % 4]) begin
                    own   = (mptr + k) % 4;
                    msel  = own;
                    mbeat = 0;
                end
            end
        end else if (req[own] && out_ready) begin
            mbeat = mbeat + 1;
            if (last_in[own] || mbeat == MB) begin
                mptr = (own + 1) % 4;
                own  = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]   eg, er;
            logic         ev, el;
            logic [W-1:0] ed;
            eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
            if (own >= 0) begin
                eg = 4'b0001 << own;
                er = {3'b000, out_ready} << own;
                ev = req[own];
                el = last_in[own];
                ed = data_in[own*W +: W];
            end
            chk("grant", grant, eg);
            chk("sel", sel, msel);
            chk("busy", busy, own >= 0);
            chk("ready_in", ready_in, er);
            chk("out_valid", out_valid, ev);
            chk("out_last", out_last, el);
            chk("out_data", out_data, ed);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        last_in   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    logic [3:0] seq3 [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                             4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] seq4 [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010};

    initial begin
        rst_n     = 1'b1;
        req       = '0;
        last_in   = '0;
        out_ready = 1'b0;
        data_in   = '0;

        // Async reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        chk("t1_grant", grant, 4'b0000);
        chk("t1_ready_in", ready_in, 4'b0000);
        chk("t1_out_valid", out_valid, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_sel", sel, 2'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // Source 0, 3-beat packet; then ptr=1 shows in the next scan.
        req = 4'b0001; last_in = 4'b0000; out_ready = 1'b1; data_in = $urandom;
        step(); chk("t2_grant", grant, 4'b0001);
        data_in = $urandom; step();
        data_in = $urandom; step();
        last_in = 4'b0001; data_in = $urandom; step();
        chk("t2_idle_grant", grant, 4'b0000);
        chk("t2_idle_busy", busy, 1'b0);
        req = 4'b1001; last_in = 4'b1001;
        step(); chk("t2_ptr1_grant", grant, 4'b1000); chk("t2_ptr1_sel", sel, 2'd3);
        step(); chk("t2_rel_grant", grant, 4'b0000);
        do_reset();

        // All request, single-beat packets.
        req = 4'b1111; last_in = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data_in = $urandom;
            step();
            chk("t3_grant_seq", grant, seq3[i]);
        end
        do_reset();

        // Burst limit: source 2 never sends last.
        req = 4'b0100; last_in = 4'b0000; out_ready = 1'b1;
        step(); chk("t4_grant", grant, 4'b0100);
        req = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            data_in = $urandom;
            step();
            chk("t4_grant_seq", grant, seq4[i]);
        end
        do_reset();

        // Back-pressure on source 0.
        req = 4'b0001; last_in = 4'b0000; out_ready = 1'b0; data_in = 32'h000000A5;
        step(); chk("t5_grant", grant, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_out_valid", out_valid, 1'b1);
            chk("t5_out_data", out_data, 8'hA5);
            chk("t5_grant_held", grant, 4'b0001);
            chk("t5_ready_in", ready_in, 4'b0000);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_burst_grant", grant, (i < 3) ? 4'b0001 : 4'b0000);
        end
        do_reset();

        // Async reset mid-packet of source 3.
        req = 4'b1000; last_in = 4'b0000; out_ready = 1'b1; data_in = 32'h5A000000;
        step(); chk("t6_grant", grant, 4'b1000);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 4'b0000);
        chk("t6_rst_ready_in", ready_in, 4'b0000);
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_out_data", out_data, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_sel", sel, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk("t6_regrant", grant, 4'b1000);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                req[b]     = ($urandom_range(3) != 0);
                last_in[b] = ($urandom_range(3) == 0);
            end
            out_ready = ($urandom_range(3) != 0);
            data_in   = $urandom;
            step();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
